// File: rtl/alu_core.sv
// Sequential ALU: single-cycle ADD/SUB, iterative shift-add MUL and restoring DIV.
// Optional drop counter for requests refused while busy: define ALU_CORE_DROP_CNT_EN.
module alu_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SEL_WIDTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic [DATA_WIDTH-1:0]     data_i_1,
  input  logic [DATA_WIDTH-1:0]     data_i_2,
  input  logic [SEL_WIDTH-1:0]      sel_i,
  output logic                      valid_o,
  output logic [2*DATA_WIDTH-1:0]   data_o,
  output logic                      busy_o
`ifdef ALU_CORE_DROP_CNT_EN
  ,
  output logic [15:0]               drop_cnt_o
`endif
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [SEL_WIDTH-1:0] OpAdd = SEL_WIDTH'(0);
  localparam logic [SEL_WIDTH-1:0] OpSub = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] OpMul = SEL_WIDTH'(2);
  localparam logic [SEL_WIDTH-1:0] OpDiv = SEL_WIDTH'(3);

  if (SEL_WIDTH != 2) begin : g_bad_sel_width
    $error("alu_core: SEL_WIDTH must be 2");
  end
  if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_bad_data_width
    $error("alu_core: DATA_WIDTH must be in 2..32");
  end

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2*W-1:0]   acc_q;    // MUL: product; DIV: {remainder, dividend/quotient}
  logic [2*W-1:0]   mcand_q;
  logic [W-1:0]     opb_q;    // MUL: multiplier (shifts right); DIV: divisor
  logic             is_div_q;

  logic [2*W-1:0]   ext_a, ext_b;
  logic [W:0]       trial;
  logic [W-1:0]     diff;
  logic [2*W-1:0]   mul_nxt, div_nxt, acc_nxt;

  assign ext_a = {{W{1'b0}}, data_i_1};
  assign ext_b = {{W{1'b0}}, data_i_2};

  always_comb begin
    mul_nxt = acc_q + (opb_q[0] ? mcand_q : '0);
    // Shift the next dividend bit into the remainder; the difference fits W bits when taken.
    trial   = {acc_q[2*W-1:W], acc_q[W-1]};
    diff    = trial[W-1:0] - opb_q;
    if (trial >= {1'b0, opb_q}) begin
      div_nxt = {diff, acc_q[W-2:0], 1'b1};
    end else begin
      div_nxt = {trial[W-1:0], acc_q[W-2:0], 1'b0};
    end
    acc_nxt = is_div_q ? div_nxt : mul_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      valid_o  <= 1'b0;
      data_o   <= '0;
      busy_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            unique case (sel_i)
              OpAdd: begin
                data_o  <= ext_a + ext_b;
                valid_o <= 1'b1;
              end
              OpSub: begin
                data_o  <= ext_a - ext_b;
                valid_o <= 1'b1;
              end
              OpMul: begin
                acc_q    <= '0;
                mcand_q  <= ext_a;
                opb_q    <= data_i_2;
                is_div_q <= 1'b0;
                cnt_q    <= CNT_W'(DATA_WIDTH);
                busy_o   <= 1'b1;
                state_q  <= StCalc;
              end
              OpDiv: begin
                acc_q    <= ext_a;
                mcand_q  <= '0;
                opb_q    <= data_i_2;
                is_div_q <= 1'b1;
                cnt_q    <= CNT_W'(DATA_WIDTH);
                busy_o   <= 1'b1;
                state_q  <= StCalc;
              end
              default: ;
            endcase
          end
        end
        StCalc: begin
          acc_q   <= acc_nxt;
          mcand_q <= mcand_q << 1;
          opb_q   <= is_div_q ? opb_q : (opb_q >> 1);
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            data_o  <= acc_nxt;
            valid_o <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALU_CORE_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_o <= '0;
    end else if (valid_i && busy_o && (drop_cnt_o != 16'hFFFF)) begin
      drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core (DATA_WIDTH=8): vector table plus hand-written corner sequences.
module tb_alu_core;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic [W-1:0] data_i_1, data_i_2;
  logic [1:0]   sel_i;
  logic         valid_o;
  logic [2*W-1:0] data_o;
  logic         busy_o;
`ifdef ALU_CORE_DROP_CNT_EN
  logic [15:0]  drop_cnt_o;
`endif

  alu_core #(.DATA_WIDTH(W), .SEL_WIDTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .data_i_1 (data_i_1),
    .data_i_2 (data_i_2),
    .sel_i    (sel_i),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .busy_o   (busy_o)
`ifdef ALU_CORE_DROP_CNT_EN
    ,
    .drop_cnt_o (drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]     sel;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;

  vec_t vecs[18];

  // Issue one request, scramble inputs after acceptance, wait for the result and check it.
  task automatic run_vec(input vec_t v, input string tag);
    int lat, busy_cnt, exp_lat, exp_busy;
    bit seen;
    @(negedge clk);
    valid_i = 1'b1; data_i_1 = v.a; data_i_2 = v.b; sel_i = v.sel;
    @(negedge clk);
    valid_i = 1'b0; data_i_1 = 8'($urandom); data_i_2 = 8'($urandom); sel_i = 2'($urandom);
    lat = 1; busy_cnt = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      if (valid_o) seen = 1'b1;
      else begin
        if (busy_o) busy_cnt++;
        @(negedge clk);
        lat++;
      end
    end
    exp_lat  = v.sel[1] ? W + 1 : 1;
    exp_busy = v.sel[1] ? W : 0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " data"}, 32'(data_o), 32'(v.exp));
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, " busy at valid"}, 32'(busy_o), 32'd0);
    @(negedge clk);
    check({tag, " single pulse"}, 32'(valid_o), 32'd0);
    check({tag, " data held"}, 32'(data_o), 32'(v.exp));
  endtask

  initial begin
    int lat, pulses;
    logic [2*W-1:0] pulse_data;
    vec_t v;

    vecs[0]  = '{ADD, 8'd200, 8'd100, 16'h012C};
    vecs[1]  = '{ADD, 8'd255, 8'd255, 16'h01FE};
    vecs[2]  = '{ADD, 8'd0,   8'd0,   16'h0000};
    vecs[3]  = '{SUB, 8'd5,   8'd10,  16'hFFFB};
    vecs[4]  = '{SUB, 8'd200, 8'd100, 16'h0064};
    vecs[5]  = '{SUB, 8'd0,   8'd255, 16'hFF01};
    vecs[6]  = '{MUL, 8'd255, 8'd255, 16'hFE01};
    vecs[7]  = '{MUL, 8'd3,   8'd4,   16'h000C};
    vecs[8]  = '{MUL, 8'd0,   8'd200, 16'h0000};
    vecs[9]  = '{MUL, 8'd128, 8'd2,   16'h0100};
    vecs[10] = '{MUL, 8'd17,  8'd15,  16'h00FF};
    vecs[11] = '{DIV, 8'd200, 8'd7,   16'h041C};
    vecs[12] = '{DIV, 8'd13,  8'd0,   16'h0DFF};
    vecs[13] = '{DIV, 8'd255, 8'd255, 16'h0001};
    vecs[14] = '{DIV, 8'd7,   8'd200, 16'h0700};
    vecs[15] = '{DIV, 8'd255, 8'd1,   16'h00FF};
    vecs[16] = '{DIV, 8'd250, 8'd16,  16'h0A0F};
    vecs[17] = '{DIV, 8'd255, 8'd200, 16'h3701};

    rst = 1'b1; valid_i = 1'b0; data_i_1 = '0; data_i_2 = '0; sel_i = '0;
    #22;
    @(negedge clk);
    rst = 1'b0;
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset data_o", 32'(data_o), 32'd0);
    check("reset busy_o", 32'(busy_o), 32'd0);
`ifdef ALU_CORE_DROP_CNT_EN
    check("reset drop_cnt", 32'(drop_cnt_o), 32'd0);
`endif

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // ADD then SUB on consecutive edges.
    @(negedge clk);
    valid_i = 1'b1; sel_i = ADD; data_i_1 = 8'd200; data_i_2 = 8'd100;
    @(negedge clk);
    sel_i = SUB; data_i_1 = 8'd5; data_i_2 = 8'd10;
    check("b2b add valid", 32'(valid_o), 32'd1);
    check("b2b add data", 32'(data_o), 32'h012C);
    check("b2b add busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    valid_i = 1'b0;
    check("b2b sub valid", 32'(valid_o), 32'd1);
    check("b2b sub data", 32'(data_o), 32'hFFFB);
    check("b2b sub busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    check("b2b end valid", 32'(valid_o), 32'd0);

    // MUL followed by ADD accepted in the valid_o cycle.
    @(negedge clk);
    valid_i = 1'b1; sel_i = MUL; data_i_1 = 8'd255; data_i_2 = 8'd255;
    @(negedge clk);
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("mul-add latency", 32'(lat), 32'(W + 1));
    check("mul-add mul data", 32'(data_o), 32'hFE01);
    valid_i = 1'b1; sel_i = ADD; data_i_1 = 8'd1; data_i_2 = 8'd1;
    @(negedge clk);
    valid_i = 1'b0;
    check("mul-add add valid", 32'(valid_o), 32'd1);
    check("mul-add add data", 32'(data_o), 32'h0002);

    // Request while busy is dropped.
    @(negedge clk);
    valid_i = 1'b1; sel_i = MUL; data_i_1 = 8'd3; data_i_2 = 8'd4;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("drop busy before", 32'(busy_o), 32'd1);
    valid_i = 1'b1; sel_i = ADD; data_i_1 = 8'd9; data_i_2 = 8'd9;
    @(negedge clk);
    valid_i = 1'b0;
    pulses = 0; pulse_data = '0;
    for (int i = 0; i < 14; i++) begin
      if (valid_o) begin
        pulses++;
        pulse_data = data_o;
      end
      @(negedge clk);
    end
    check("drop pulse count", 32'(pulses), 32'd1);
    check("drop pulse data", 32'(pulse_data), 32'h000C);
    check("drop final data", 32'(data_o), 32'h000C);
`ifdef ALU_CORE_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt_o), 32'd1);
`endif

    // Asynchronous reset mid-DIV abandons the operation.
    @(negedge clk);
    valid_i = 1'b1; sel_i = DIV; data_i_1 = 8'd100; data_i_2 = 8'd3;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy before", 32'(busy_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst async valid", 32'(valid_o), 32'd0);
    check("rst async data", 32'(data_o), 32'd0);
    check("rst async busy", 32'(busy_o), 32'd0);
`ifdef ALU_CORE_DROP_CNT_EN
    check("rst drop_cnt", 32'(drop_cnt_o), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (valid_o) pulses++;
      @(negedge clk);
    end
    check("rst no late valid", 32'(pulses), 32'd0);
    check("rst idle busy", 32'(busy_o), 32'd0);
    v = '{ADD, 8'd2, 8'd3, 16'h0005};
    run_vec(v, "post-rst add");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
